minbd_inject_stage: RTL and testbench

//  Router stage directly upstream of the 2x2 deflection arbiter. Takes the two 11-bit

---
 rtl/minbd_inject_stage.sv | 191 +++++++++++++++++++
 tb/tb_minbd_inject_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/minbd_inject_stage.sv
// ---------------------------------------------------------------------------
// minbd_inject_stage
//   Router stage directly upstream of the 2x2 deflection arbiter. Each cycle it
//   ejects at most one locally-destined flit, reinjects a side-buffer flit into
//   a free lane, and injects a local flit into whatever lane is still free.
//   When local injection has been starved for STARVE_LIMIT cycles and both lanes
//   are occupied, one non-golden in-flight flit is redirected into the
//   side-buffer FIFO so the local flit can take its place.
//   Flit format: [10] golden, [9] valid, [8:6] port code, [5:0] payload.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   inp1, inp2   in   incoming flits, lanes 1 and 2
//   inj_valid    in   local flit offered
//   inj_flit     in   local flit {port code, payload}
//   inj_ready    out  combinational; local flit taken when inj_valid && inj_ready
//   out1, out2   out  registered lane flits to the arbiter
//   eject_valid  out  registered; eject_flit holds a flit
//   eject_flit   out  registered ejected flit (zero when eject_valid is low)
//   sb_count     out  side-buffer occupancy
// ---------------------------------------------------------------------------
module minbd_inject_stage #(
    parameter int         DEPTH        = 4,
    parameter logic [2:0] LOCAL_CODE   = 3'b000,
    parameter int         STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [10:0]                  inp1,
    input  logic [10:0]                  inp2,
    input  logic                         inj_valid,
    input  logic [8:0]                   inj_flit,
    output logic                         inj_ready,
    output logic [10:0]                  out1,
    output logic [10:0]                  out2,
    output logic                         eject_valid,
    output logic [10:0]                  eject_flit,
    output logic [$clog2(DEPTH+1)-1:0]   sb_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  LIMIT_C = ST_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    // Side-buffer storage and state
    logic [10:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [ST_W-1:0]  r_starve;

    // Registered outputs
    logic [10:0]      r_out1;
    logic [10:0]      r_out2;
    logic             r_eject_valid;
    logic [10:0]      r_eject_flit;

    // Per-cycle decisions
    logic             w_loc1, w_loc2;
    logic             w_ej1, w_ej2;
    logic             w_free1, w_free2;
    logic             w_avail1, w_avail2;
    logic [10:0]      w_lane1, w_lane2;
    logic [10:0]      w_eject_flit;
    logic [10:0]      w_inj;
    logic             w_pop, w_push, w_accept;
    logic [10:0]      w_push_data;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_loc1 = inp1[9] && (inp1[8:6] == LOCAL_CODE);
    assign w_loc2 = inp2[9] && (inp2[8:6] == LOCAL_CODE);
    assign w_inj  = {2'b01, inj_flit};

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        // Eject: golden beats non-golden, lane 1 wins ties.
        w_ej1 = w_loc1 && (!w_loc2 || inp1[10] || !inp2[10]);
        w_ej2 = w_loc2 && !w_ej1;

        w_free1 = !inp1[9] || w_ej1;
        w_free2 = !inp2[9] || w_ej2;

        w_lane1 = w_free1 ? 11'h000 : inp1;
        w_lane2 = w_free2 ? 11'h000 : inp2;

        w_eject_flit = w_ej1 ? inp1 : (w_ej2 ? inp2 : 11'h000);

        w_avail1    = w_free1;
        w_avail2    = w_free2;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_push_data = 11'h000;
        w_accept    = 1'b0;

        // Reinject the FIFO head into the lowest free lane.
        if (r_count != '0 && (w_free1 || w_free2)) begin
            w_pop = 1'b1;
            if (w_free1) begin
                w_lane1  = r_mem[r_head];
                w_avail1 = 1'b0;
            end else begin
                w_lane2  = r_mem[r_head];
                w_avail2 = 1'b0;
            end
        end

        if (inj_valid && !rst) begin
            if (w_avail1) begin
                w_lane1  = w_inj;
                w_accept = 1'b1;
            end else if (w_avail2) begin
                w_lane2  = w_inj;
                w_accept = 1'b1;
            end else if (!w_free1 && !w_free2 && r_starve == LIMIT_C &&
                         r_count < DEPTH_C && (!inp1[10] || !inp2[10])) begin
                // Both lanes hold through-traffic: displace a non-golden one
                // into the side buffer, lane 2 first.
                w_push   = 1'b1;
                w_accept = 1'b1;
                if (!inp2[10]) begin
                    w_push_data = inp2;
                    w_lane2     = w_inj;
                end else begin
                    w_push_data = inp1;
                    w_lane1     = w_inj;
                end
            end
        end
    end

    assign inj_ready = w_accept;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out1        <= 11'h000;
            r_out2        <= 11'h000;
            r_eject_valid <= 1'b0;
            r_eject_flit  <= 11'h000;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_starve      <= '0;
        end else begin
            r_out1        <= w_lane1;
            r_out2        <= w_lane2;
            r_eject_valid <= w_ej1 || w_ej2;
            r_eject_flit  <= w_eject_flit;

            // Push and pop never coincide: pop needs a free lane, push needs none.
            if (w_push) begin
                r_tail  <= ptr_next(r_tail);
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop) begin
                r_head  <= ptr_next(r_head);
                r_count <= r_count - CNT_W'(1);
            end

            if (w_accept) begin
                r_starve <= '0;
            end else if (inj_valid && r_starve != LIMIT_C) begin
                r_starve <= r_starve + ST_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only read when
    // r_count says they were written, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_push_data;
        end
    end

    assign out1        = r_out1;
    assign out2        = r_out2;
    assign eject_valid = r_eject_valid;
    assign eject_flit  = r_eject_flit;
    assign sb_count    = r_count;

endmodule

// File: tb/tb_minbd_inject_stage.sv
// ---------------------------------------------------------------------------
// tb_minbd_inject_stage
//   Directed bench for minbd_inject_stage with DEPTH=2, STARVE_LIMIT=4.
//   Inputs change on the falling edge; inj_ready is sampled 1 ns later and the
//   registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_minbd_inject_stage;

    logic        clk;
    logic        rst;
    logic [10:0] inp1, inp2;
    logic        inj_valid;
    logic [8:0]  inj_flit;
    logic        inj_ready;
    logic [10:0] out1, out2;
    logic        eject_valid;
    logic [10:0] eject_flit;
    logic [1:0]  sb_count;

    int checks   = 0;
    int failures = 0;

    minbd_inject_stage #(
        .DEPTH        (2),
        .LOCAL_CODE   (3'b000),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inp1        (inp1),
        .inp2        (inp2),
        .inj_valid   (inj_valid),
        .inj_flit    (inj_flit),
        .inj_ready   (inj_ready),
        .out1        (out1),
        .out2        (out2),
        .eject_valid (eject_valid),
        .eject_flit  (eject_flit),
        .sb_count    (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [10:0] a, input logic [10:0] b,
                         input logic v, input logic [8:0] f);
        @(negedge clk);
        inp1 = a; inp2 = b; inj_valid = v; inj_flit = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inp1 = 11'h000; inp2 = 11'h000; inj_valid = 1'b1; inj_flit = 9'h0C5;
        #2;
        checks++; if (inj_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", inj_ready); end
        checks++; if (out1 !== 11'h000 || out2 !== 11'h000) begin failures++; $display("FAIL reset_lanes got=%h/%h exp=000/000", out1, out2); end
        checks++; if (eject_valid !== 1'b0 || eject_flit !== 11'h000) begin failures++; $display("FAIL reset_eject got=%b/%h exp=0/000", eject_valid, eject_flit); end
        checks++; if (sb_count !== 2'd0) begin failures++; $display("FAIL reset_sb got=%0d exp=0", sb_count); end
        repeat (2) tick();
        checks++; if (out1 !== 11'h000 || inj_ready !== 1'b0) begin failures++; $display("FAIL reset_held got=%h/%b exp=000/0", out1, inj_ready); end
        @(negedge clk);
        inj_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_eject_inject();
        drive(11'h215, 11'h000, 1'b1, 9'h0C5);
        checks++; if (inj_ready !== 1'b1) begin failures++; $display("FAIL t2_ready got=%0b exp=1", inj_ready); end
        tick();
        checks++; if (eject_valid !== 1'b1 || eject_flit !== 11'h215) begin failures++; $display("FAIL t2_eject got=%b/%h exp=1/215", eject_valid, eject_flit); end
        checks++; if (out1 !== 11'h2C5 || out2 !== 11'h000) begin failures++; $display("FAIL t2_lanes got=%h/%h exp=2c5/000", out1, out2); end
    endtask

    task automatic test_eject_priority();
        drive(11'h215, 11'h216, 1'b0, 9'h000);
        tick();
        checks++; if (eject_flit !== 11'h215 || out2 !== 11'h216 || out1 !== 11'h000) begin failures++; $display("FAIL t3_tie got=%h/%h/%h exp=215/000/216", eject_flit, out1, out2); end
        drive(11'h215, 11'h616, 1'b0, 9'h000);
        tick();
        checks++; if (eject_flit !== 11'h616 || out1 !== 11'h215 || out2 !== 11'h000) begin failures++; $display("FAIL t3_golden got=%h/%h/%h exp=616/215/000", eject_flit, out1, out2); end
        drive(11'h2C1, 11'h000, 1'b0, 9'h000);
        tick();
        checks++; if (eject_valid !== 1'b0 || eject_flit !== 11'h000 || out1 !== 11'h2C1) begin failures++; $display("FAIL t3_none got=%b/%h/%h exp=0/000/2c1", eject_valid, eject_flit, out1); end
    endtask

    // Blocked injection for STARVE_LIMIT cycles, then forced redirect of lane 2.
    task automatic starve_redirect(input logic [10:0] b, input logic [1:0] exp_sb);
        logic        exp_ready;
        logic [10:0] exp_out2;
        logic [1:0]  exp_cnt;
        for (int c = 0; c < 5; c++) begin
            drive(11'h2C1, b, 1'b1, 9'h081);
            exp_ready = (c == 4);
            checks++; if (inj_ready !== exp_ready) begin failures++; $display("FAIL starve_ready c=%0d got=%0b exp=%0b", c, inj_ready, exp_ready); end
            tick();
            exp_out2 = (c == 4) ? 11'h281 : b;
            exp_cnt  = (c == 4) ? exp_sb : exp_sb - 2'd1;
            checks++; if (out1 !== 11'h2C1 || out2 !== exp_out2 || sb_count !== exp_cnt) begin failures++; $display("FAIL starve_out c=%0d got=%h/%h/%0d exp=2c1/%h/%0d", c, out1, out2, sb_count, exp_out2, exp_cnt); end
        end
    endtask

    task automatic test_starve_redirect();
        starve_redirect(11'h2C1, 2'd1);
    endtask

    task automatic test_reinject();
        drive(11'h2C1, 11'h000, 1'b0, 9'h081);
        checks++; if (inj_ready !== 1'b0) begin failures++; $display("FAIL t5_ready got=%0b exp=0", inj_ready); end
        tick();
        checks++; if (out1 !== 11'h2C1 || out2 !== 11'h2C1 || sb_count !== 2'd0) begin failures++; $display("FAIL t5_pop got=%h/%h/%0d exp=2c1/2c1/0", out1, out2, sb_count); end
    endtask

    task automatic test_fifo_full();
        starve_redirect(11'h2C2, 2'd1);
        starve_redirect(11'h2C3, 2'd2);
        for (int c = 0; c < 8; c++) begin
            drive(11'h2C1, 11'h2C1, 1'b1, 9'h081);
            checks++; if (inj_ready !== 1'b0) begin failures++; $display("FAIL full_ready c=%0d got=%0b exp=0", c, inj_ready); end
            tick();
            checks++; if (out2 !== 11'h2C1 || sb_count !== 2'd2) begin failures++; $display("FAIL full_out c=%0d got=%h/%0d exp=2c1/2", c, out2, sb_count); end
        end
        // Drain one entry with injection idle: oldest entry comes out first.
        drive(11'h2C1, 11'h000, 1'b0, 9'h081);
        tick();
        checks++; if (out2 !== 11'h2C2 || sb_count !== 2'd1) begin failures++; $display("FAIL full_drain got=%h/%0d exp=2c2/1", out2, sb_count); end
        // Counter stayed saturated, so the next blocked cycle redirects at once.
        drive(11'h2C1, 11'h2C4, 1'b1, 9'h081);
        checks++; if (inj_ready !== 1'b1) begin failures++; $display("FAIL sat_ready got=%0b exp=1", inj_ready); end
        tick();
        checks++; if (out1 !== 11'h2C1 || out2 !== 11'h281 || sb_count !== 2'd2) begin failures++; $display("FAIL sat_out got=%h/%h/%0d exp=2c1/281/2", out1, out2, sb_count); end
    endtask

    task automatic test_reset_mid();
        drive(11'h000, 11'h000, 1'b1, 9'h0C5);
        rst = 1'b1;
        #1;
        checks++; if (out1 !== 11'h000 || out2 !== 11'h000) begin failures++; $display("FAIL t1_lanes got=%h/%h exp=000/000", out1, out2); end
        checks++; if (eject_valid !== 1'b0 || eject_flit !== 11'h000 || sb_count !== 2'd0) begin failures++; $display("FAIL t1_state got=%b/%h/%0d exp=0/000/0", eject_valid, eject_flit, sb_count); end
        checks++; if (inj_ready !== 1'b0) begin failures++; $display("FAIL t1_ready got=%0b exp=0", inj_ready); end
        #2;
        rst = 1'b0;
        inj_valid = 1'b0;
        drive(11'h000, 11'h000, 1'b0, 9'h000);
        tick();
        checks++; if (out1 !== 11'h000 || out2 !== 11'h000 || sb_count !== 2'd0) begin failures++; $display("FAIL t1_empty got=%h/%h/%0d exp=000/000/0", out1, out2, sb_count); end
    endtask

    task automatic test_golden_block();
        for (int c = 0; c < 8; c++) begin
            drive(11'h6C1, 11'h6C1, 1'b1, 9'h081);
            checks++; if (inj_ready !== 1'b0) begin failures++; $display("FAIL gold_ready c=%0d got=%0b exp=0", c, inj_ready); end
            tick();
            checks++; if (out1 !== 11'h6C1 || out2 !== 11'h6C1 || sb_count !== 2'd0) begin failures++; $display("FAIL gold_out c=%0d got=%h/%h/%0d exp=6c1/6c1/0", c, out1, out2, sb_count); end
        end
        // Lane 2 golden: lane 1 is displaced instead.
        drive(11'h2C1, 11'h6C1, 1'b1, 9'h081);
        checks++; if (inj_ready !== 1'b1) begin failures++; $display("FAIL lane1_ready got=%0b exp=1", inj_ready); end
        tick();
        checks++; if (out1 !== 11'h281 || out2 !== 11'h6C1 || sb_count !== 2'd1) begin failures++; $display("FAIL lane1_out got=%h/%h/%0d exp=281/6c1/1", out1, out2, sb_count); end
        drive(11'h6C1, 11'h000, 1'b0, 9'h081);
        tick();
        checks++; if (out1 !== 11'h6C1 || out2 !== 11'h2C1 || sb_count !== 2'd0) begin failures++; $display("FAIL lane1_pop got=%h/%h/%0d exp=6c1/2c1/0", out1, out2, sb_count); end
    endtask

    initial begin
        test_reset();
        test_eject_inject();
        test_eject_priority();
        test_starve_redirect();
        test_reinject();
        test_fifo_full();
        test_reset_mid();
        test_golden_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
